// File: rtl/alu_result_display.sv
// ALU result display: double-buffered {carry, result} capture driving a 4-digit
// multiplexed hex 7-segment display, with carry shown on the digit-0 decimal point.
module alu_result_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int SEG_ACT_LOW = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] result,
  input  logic        carry_out,
  input  logic        blank_lead,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic [16:0] disp_value
);

  localparam int                DIV_W    = $clog2(REFRESH_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic              POL_LOW  = (SEG_ACT_LOW != 0);
  localparam logic [3:0]        AN_OFF   = POL_LOW ? 4'hF : 4'h0;
  localparam logic [6:0]        SEG_OFF  = POL_LOW ? 7'h7F : 7'h00;
  localparam logic              DP_OFF   = POL_LOW;

  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_digit;
  logic [16:0]      r_stage;
  logic             r_pending;
  logic [16:0]      r_disp;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;

  logic             w_div_last;
  logic             w_frame_end;
  logic [3:0]       w_nib;
  logic             w_lead_zero;
  logic [6:0]       w_seg_al;
  logic [3:0]       w_an_al;
  logic             w_dp_al;

  // Glyphs are held in active-low gfedcba form; polarity is applied at the output register.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_glyph = 7'b1000000;
      4'h1:    hex_glyph = 7'b1111001;
      4'h2:    hex_glyph = 7'b0100100;
      4'h3:    hex_glyph = 7'b0110000;
      4'h4:    hex_glyph = 7'b0011001;
      4'h5:    hex_glyph = 7'b0010010;
      4'h6:    hex_glyph = 7'b0000010;
      4'h7:    hex_glyph = 7'b1111000;
      4'h8:    hex_glyph = 7'b0000000;
      4'h9:    hex_glyph = 7'b0010000;
      4'hA:    hex_glyph = 7'b0001000;
      4'hB:    hex_glyph = 7'b0000011;
      4'hC:    hex_glyph = 7'b1000110;
      4'hD:    hex_glyph = 7'b0100001;
      4'hE:    hex_glyph = 7'b0000110;
      default: hex_glyph = 7'b0001110;
    endcase
  endfunction

  assign w_div_last  = (r_div == DIV_LAST);
  assign w_frame_end = w_div_last && (r_digit == 2'd3);

  always_comb begin
    w_nib       = 4'h0;
    w_lead_zero = 1'b0;
    case (r_digit)
      2'd0: w_nib = r_disp[3:0];
      2'd1: begin
        w_nib       = r_disp[7:4];
        w_lead_zero = (r_disp[15:4] == 12'h000);
      end
      2'd2: begin
        w_nib       = r_disp[11:8];
        w_lead_zero = (r_disp[15:8] == 8'h00);
      end
      default: begin
        w_nib       = r_disp[15:12];
        w_lead_zero = (r_disp[15:12] == 4'h0);
      end
    endcase
  end

  assign w_seg_al = (blank_lead && w_lead_zero) ? 7'h7F : hex_glyph(w_nib);
  assign w_an_al  = ~(4'b0001 << r_digit);
  assign w_dp_al  = ~((r_digit == 2'd0) && r_disp[16]);

  // Scan divider, staging and frame-boundary commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div     <= '0;
      r_digit   <= 2'd0;
      r_stage   <= 17'd0;
      r_pending <= 1'b0;
      r_disp    <= 17'd0;
    end else begin
      r_div <= w_div_last ? '0 : r_div + 1'b1;
      if (w_div_last)
        r_digit <= r_digit + 2'd1;
      if (load)
        r_stage <= {carry_out, result};
      // A load on the commit cycle keeps pending set so the new value lands next frame.
      if (w_frame_end && r_pending)
        r_disp <= r_stage;
      if (load)
        r_pending <= 1'b1;
      else if (w_frame_end)
        r_pending <= 1'b0;
    end
  end

  // Output register: an, seg and dp all change on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
      r_dp  <= DP_OFF;
    end else begin
      r_an  <= POL_LOW ? w_an_al  : ~w_an_al;
      r_seg <= POL_LOW ? w_seg_al : ~w_seg_al;
      r_dp  <= POL_LOW ? w_dp_al  : ~w_dp_al;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign disp_value = r_disp;

endmodule

// File: tb/tb_alu_result_display.sv
// Scoreboard bench for alu_result_display: random and directed loads checked against a
// frame-level reference model of commits and per-cycle expected display outputs.
module tb_alu_result_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] result;
  logic        carry_out;
  logic        blank_lead;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [16:0] disp_value;

  int n_checks = 0;
  int n_fail   = 0;

  alu_result_display #(.REFRESH_DIV(4), .SEG_ACT_LOW(1)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .result(result), .carry_out(carry_out),
    .blank_lead(blank_lead), .seg(seg), .dp(dp), .an(an), .disp_value(disp_value)
  );

  always #5 clk = ~clk;

  logic [6:0] GLYPH [0:15] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: edge k after reset release shows digit (k/4)%4; frame ends on k%16==15.
  int unsigned k = 0;
  logic [16:0] m_stage = '0;
  logic [16:0] m_disp  = '0;
  bit          m_pend  = 0;
  logic [3:0]  exp_an  = 4'hF;
  logic [6:0]  exp_seg = 7'h7F;
  logic        exp_dp  = 1'b1;
  logic [16:0] exp_q [$];

  always @(posedge clk or negedge rst_n) begin
    int          d;
    logic [15:0] sh;
    if (!rst_n) begin
      k = 0; m_stage = '0; m_disp = '0; m_pend = 0;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
      exp_q.delete();
    end else begin
      d       = int'((k / 4) % 4);
      sh      = m_disp[15:0] >> (4 * d);
      exp_an  = ~(4'b0001 << d);
      exp_seg = (blank_lead && d != 0 && sh == 16'h0) ? 7'h7F : GLYPH[sh[3:0]];
      exp_dp  = !(d == 0 && m_disp[16]);
      if (k % 16 == 15 && m_pend) begin
        if (m_stage != m_disp) exp_q.push_back(m_stage);
        m_disp = m_stage;
        m_pend = 0;
      end
      if (load) begin
        m_stage = {carry_out, result};
        m_pend  = 1;
      end
      k++;
    end
  end

  // Monitor: display outputs every cycle; disp_value changes popped from the scoreboard
  logic [16:0] last_disp = '0;
  always @(negedge clk) begin
    logic [16:0] e;
    check("an", 32'(an), 32'(exp_an));
    check("seg", 32'(seg), 32'(exp_seg));
    check("dp", 32'(dp), 32'(exp_dp));
    if (!rst_n) begin
      last_disp = '0;
    end else begin
      if (k > 0) check("an_onehot", 32'($countones(~an)), 32'd1);
      if (disp_value != last_disp) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL disp_unexpected: got %0h expected %0h at %0t", disp_value, last_disp, $time);
        end else begin
          e = exp_q.pop_front();
          check("disp_commit", 32'(disp_value), 32'(e));
        end
        last_disp = disp_value;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_load(input logic [15:0] v, input logic c);
    load = 1'b1; result = v; carry_out = c;
    step();
    load = 1'b0;
  endtask

  task automatic wait_phase(input int unsigned ph);
    int guard = 0;
    while ((k % 16) != ph && guard < 64) begin
      step();
      guard++;
    end
    check("phase_wait", 32'(k % 16), 32'(ph));
  endtask

  initial begin
    logic [15:0] v;
    rst_n = 1'b1; load = 1'b0; result = '0; carry_out = 1'b0; blank_lead = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_disp", 32'(disp_value), 32'h0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    check("rel_an", 32'(an), 32'b1110);
    check("rel_seg", 32'(seg), 32'b1000000);

    do_load(16'hA5C3, 1'b1);
    repeat (32) step();
    check("disp_A5C3", 32'(disp_value), 32'h1A5C3);

    blank_lead = 1'b1;
    do_load(16'h0007, 1'b0);
    repeat (32) step();
    check("disp_0007", 32'(disp_value), 32'h00007);
    do_load(16'h0000, 1'b0);
    repeat (32) step();
    check("disp_0000", 32'(disp_value), 32'h00000);
    blank_lead = 1'b0;

    wait_phase(0);
    do_load(16'h1111, 1'b0);
    step();
    do_load(16'h2222, 1'b0);
    repeat (32) step();
    check("disp_last_wins", 32'(disp_value), 32'h02222);

    wait_phase(0);
    do_load(16'h4444, 1'b0);
    wait_phase(15);
    do_load(16'h3333, 1'b0);
    check("commit_old_stage", 32'(disp_value), 32'h04444);
    repeat (16) step();
    check("commit_next_frame", 32'(disp_value), 32'h03333);

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 31) == 0) blank_lead = ~blank_lead;
      if ($urandom_range(0, 7) == 0) begin
        v = 16'($urandom);
        v = v >> (4 * $urandom_range(0, 3));
        do_load(v, 1'($urandom));
      end else begin
        step();
      end
    end
    blank_lead = 1'b0;
    repeat (40) step();

    wait_phase(0);
    do_load(16'hBEEF, 1'b1);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_an", 32'(an), 32'hF);
    check("mid_rst_seg", 32'(seg), 32'h7F);
    check("mid_rst_dp", 32'(dp), 32'h1);
    check("mid_rst_disp", 32'(disp_value), 32'h0);
    step();
    step();
    rst_n = 1'b1;
    repeat (40) step();
    check("pending_discarded", 32'(disp_value), 32'h0);

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
